prbsgen_parallel_fab: RTL and testbench

Parallel PRBS7 pattern generator (x^7 + x^6 + 1), the transmit-side counterpart of the nbits-wide fabric PRBS7 checker used in the RX IOD bit-alignment test path. After enable it sends a fixed training word for a programmable number of cycles so the receiver can bit-align. It then streams one nbits-wide PRBS7 word per clock, with single-bit error injection on request and a count of PRBS words sent.

---
 rtl/prbsgen_parallel_fab.sv | 130 +++++++++++++
 tb/tb_prbsgen_parallel_fab.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbsgen_parallel_fab.sv
// Parallel PRBS7 (x^7 + x^6 + 1) pattern generator: training preamble after enable, then one
// nbits-wide PRBS word per clock with single-bit error injection and a saturating word counter.
module prbsgen_parallel_fab #(
  parameter int unsigned      nbits         = 8,
  parameter int unsigned      TRAIN_WORDS   = 16,
  parameter logic [nbits-1:0] TRAIN_PATTERN = nbits'(8'hF0),
  parameter logic [6:0]       SEED          = 7'h7F,
  parameter int unsigned      CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             prbs_en_i,
  input  logic             inj_err_i,
  output logic [nbits-1:0] data_out_o,
  output logic             prbs_valid_o,
  output logic             inj_ack_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam int unsigned    TW_W     = (TRAIN_WORDS > 0) ? $clog2(TRAIN_WORDS + 1) : 1;
  localparam logic [TW_W-1:0] TW_LAST = TW_W'(TRAIN_WORDS);
  localparam logic [6:0]     SEED_EFF = (SEED == 7'd0) ? 7'h7F : SEED;

  typedef enum logic [1:0] {IDLE, TRAIN, PRBS} state_e;

  // Serial expansion of s[n] = s[n-6] ^ s[n-7]; first generated bit lands in the MSB.
  function automatic logic [nbits-1:0] prbs_word(input logic [6:0] hist);
    logic [6:0]       s;
    logic [nbits-1:0] w;
    logic             b;
    s = hist;
    w = '0;
    for (int i = 0; i < int'(nbits); i++) begin
      b = s[5] ^ s[6];
      s = {s[5:0], b};
      w = {w[nbits-2:0], b};
    end
    return w;
  endfunction

  state_e            state_q, state_d;
  logic [TW_W-1:0]   train_q, train_d;
  logic [6:0]        h_q, h_d;
  logic              pend_q, pend_d;
  logic [nbits-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [nbits-1:0]  w;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      train_q <= '0;
      h_q     <= SEED_EFF;
      pend_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      train_q <= train_d;
      h_q     <= h_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  // Transition decided from the current state, outputs from the state being entered.
  always_comb begin
    state_d = state_q;
    train_d = train_q;
    h_d     = h_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    data_d  = '0;
    valid_d = 1'b0;
    ack_d   = 1'b0;
    w       = prbs_word(h_q);

    case (state_q)
      IDLE: begin
        if (prbs_en_i) begin
          cnt_d   = '0;
          train_d = TW_W'(1);
          state_d = (TRAIN_WORDS == 0) ? PRBS : TRAIN;
        end
      end
      TRAIN: begin
        pend_d = pend_q | inj_err_i;
        if (train_q == TW_LAST) state_d = PRBS;
        else                    train_d = train_q + TW_W'(1);
      end
      PRBS:    pend_d = pend_q | inj_err_i;
      default: state_d = IDLE;
    endcase

    if (!prbs_en_i) state_d = IDLE;

    case (state_d)
      TRAIN: data_d = TRAIN_PATTERN;
      PRBS: begin
        valid_d = 1'b1;
        data_d  = w;
        h_d     = w[6:0];
        if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
        // History advances from the clean word so injection never disturbs the sequence.
        if (pend_q) begin
          data_d[0] = ~w[0];
          ack_d     = 1'b1;
          pend_d    = inj_err_i;
        end
      end
      default: begin
        h_d    = SEED_EFF;
        pend_d = 1'b0;
      end
    endcase
  end

  assign data_out_o   = data_q;
  assign prbs_valid_o = valid_q;
  assign inj_ack_o    = ack_q;
  assign word_cnt_o   = cnt_q;

endmodule

// File: tb/tb_prbsgen_parallel_fab.sv
// Self-checking bench for prbsgen_parallel_fab: default config with a scoreboarded reference,
// a no-training config streamed through a PRBS7 recurrence checker, and a 4-bit counter config.
module tb_prbsgen_parallel_fab;

  localparam int unsigned TW    = 16;
  localparam int unsigned NGOLD = 1100;

  typedef struct packed {
    logic [7:0]  data;
    logic        valid;
    logic        ack;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic en0, inj0, en1, inj1, en2, inj2;
  logic [7:0]  d0, d1, d2;
  logic        v0, v1, v2, a0, a1, a2;
  logic [31:0] c0, c1;
  logic [3:0]  c2;

  prbsgen_parallel_fab dut0 (
    .clk_i(clk), .resetn_i(resetn), .prbs_en_i(en0), .inj_err_i(inj0),
    .data_out_o(d0), .prbs_valid_o(v0), .inj_ack_o(a0), .word_cnt_o(c0));

  prbsgen_parallel_fab #(.TRAIN_WORDS(0)) dut1 (
    .clk_i(clk), .resetn_i(resetn), .prbs_en_i(en1), .inj_err_i(inj1),
    .data_out_o(d1), .prbs_valid_o(v1), .inj_ack_o(a1), .word_cnt_o(c1));

  prbsgen_parallel_fab #(.TRAIN_WORDS(0), .CNT_W(4)) dut2 (
    .clk_i(clk), .resetn_i(resetn), .prbs_en_i(en2), .inj_err_i(inj2),
    .data_out_o(d2), .prbs_valid_o(v2), .inj_ack_o(a2), .word_cnt_o(c2));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] gold [NGOLD];
  exp_t sb [$];

  // Reference state for dut0: 0 idle, 1 training, 2 prbs.
  int          m_st, m_tc, m_wi;
  logic [31:0] m_cnt;
  logic        m_pend;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Checker equation s[i]^s[i+6]^s[i+7] over the previous word's low bits and the current word.
  function automatic logic rec_err(input logic [7:0] prev, input logic [7:0] cur);
    logic [14:0] t;
    t = {prev[6:0], cur};
    return |((t ^ (t >> 6) ^ (t >> 7)) & 15'h00FF);
  endfunction

  task automatic model_reset();
    m_st = 0; m_tc = 0; m_wi = 0; m_cnt = '0; m_pend = 1'b0;
  endtask

  task automatic step0(input logic en, input logic inj, input string tag);
    exp_t e;
    int   ns;
    logic served;
    en0 = en;
    inj0 = inj;
    if (!en)           ns = 0;
    else if (m_st == 0) ns = (TW > 0) ? 1 : 2;
    else if (m_st == 1) ns = (m_tc == int'(TW)) ? 2 : 1;
    else               ns = 2;
    e = '0;
    served = 1'b0;
    if (ns != 0 && m_st == 0) begin
      m_cnt = '0; m_tc = 0; m_wi = 0;
    end
    if (ns == 1) begin
      e.data = 8'hF0;
      m_tc++;
    end
    if (ns == 2) begin
      e.data  = gold[m_wi];
      m_wi++;
      e.valid = 1'b1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      served = m_pend;
      if (served) begin
        e.data[0] = ~e.data[0];
        e.ack = 1'b1;
      end
    end
    e.cnt = m_cnt;
    if (ns == 0 || m_st == 0) m_pend = 1'b0;
    else if (served)          m_pend = inj;
    else                      m_pend = m_pend | inj;
    m_st = ns;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " data"},  64'(d0), 64'(e.data));
    chk({tag, " valid"}, 64'(v0), 64'(e.valid));
    chk({tag, " ack"},   64'(a0), 64'(e.ack));
    chk({tag, " cnt"},   64'(c0), 64'(e.cnt));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    bit         bs [$];
    logic [7:0] wv;
    logic [7:0] prev;
    int         rec_errs;
    int         k;

    // Golden PRBS7 stream built bit by bit from the seed history 7'h7F.
    for (int i = 0; i < 7; i++) bs.push_back(1'b1);
    for (int n = 7; n < 7 + int'(NGOLD) * 8; n++) bs.push_back(bs[n-6] ^ bs[n-7]);
    for (int g = 0; g < int'(NGOLD); g++) begin
      wv = '0;
      for (int j = 0; j < 8; j++) wv = {wv[6:0], bs[7 + 8*g + j]};
      gold[g] = wv;
    end

    resetn = 1'b0;
    en0 = 0; inj0 = 0; en1 = 0; inj1 = 0; en2 = 0; inj2 = 0;
    #12;
    chk("reset data", 64'(d0), 64'h0);
    chk("reset valid", 64'(v0), 64'h0);
    chk("reset ack", 64'(a0), 64'h0);
    chk("reset cnt", 64'(c0), 64'h0);
    chk("reset dut1 data", 64'(d1), 64'h0);
    chk("reset dut2 cnt", 64'(c2), 64'h0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // Idle, including an injection pulse that must be ignored.
    step0(0, 0, "idle0");
    step0(0, 1, "idle inj");
    step0(0, 0, "idle1");

    // Run A: full training then PRBS, injections in PRBS.
    for (int i = 0; i < int'(TW); i++) step0(1, 0, $sformatf("A train%0d", i));
    chk("A last train word", 64'(d0), 64'hF0);
    step0(1, 0, "A w1");
    chk("A first prbs word", 64'(d0), 64'h02);
    chk("A cnt after w1", 64'(c0), 64'd1);
    step0(1, 0, "A w2");
    chk("A second prbs word", 64'(d0), 64'h0C);
    for (int i = 0; i < 3; i++) step0(1, 0, $sformatf("A w%0d", i + 3));
    step0(1, 1, "A inj req");
    step0(1, 0, "A inj served");
    chk("A ack pulse", 64'(a0), 64'h1);
    step0(1, 0, "A after inj");
    step0(1, 1, "A req1");
    step0(1, 1, "A serve1 req2");
    step0(1, 0, "A serve2");
    step0(1, 0, "A clean");

    // Disable then re-enable with injection during training.
    step0(0, 0, "dis0");
    chk("dis data zero", 64'(d0), 64'h0);
    step0(0, 0, "dis1");
    step0(1, 0, "B train0");
    step0(1, 1, "B train1 inj");
    for (int i = 2; i < int'(TW); i++) step0(1, 0, $sformatf("B train%0d", i));
    step0(1, 0, "B w1");
    chk("B corrupted first word", 64'(d0), 64'h03);
    chk("B first word ack", 64'(a0), 64'h1);
    step0(1, 0, "B w2");
    chk("B second word clean", 64'(d0), 64'h0C);
    for (int i = 0; i < 3; i++) step0(1, 0, $sformatf("B w%0d", i + 3));

    // Asynchronous reset between edges.
    #3;
    resetn = 1'b0;
    #1;
    chk("async rst data", 64'(d0), 64'h0);
    chk("async rst valid", 64'(v0), 64'h0);
    chk("async rst cnt", 64'(c0), 64'h0);
    en0 = 1'b0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    step0(1, 0, "post rst train0");

    // No-training config: stream 1000 words through the recurrence checker.
    en0 = 1'b0;
    en1 = 1'b1;
    @(posedge clk);
    #1;
    chk("T0 first word", 64'(d1), 64'h02);
    chk("T0 first valid", 64'(v1), 64'h1);
    chk("T0 first cnt", 64'(c1), 64'd1);
    prev = d1;
    rec_errs = 0;
    for (k = 1; k < 1000; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("T0 word%0d", k), 64'(d1), 64'(gold[k]));
      rec_errs += int'(rec_err(prev, d1));
      prev = d1;
    end
    chk("T0 checker clean", 64'(rec_errs), 64'h0);
    chk("T0 cnt 1000", 64'(c1), 64'd1000);
    inj1 = 1'b1;
    @(posedge clk);
    #1;
    inj1 = 1'b0;
    chk("T0 req word", 64'(d1), 64'(gold[1000]));
    chk("T0 req no ack", 64'(a1), 64'h0);
    prev = d1;
    @(posedge clk);
    #1;
    chk("T0 inj word", 64'(d1), 64'(gold[1001] ^ 8'h01));
    chk("T0 inj ack", 64'(a1), 64'h1);
    chk("T0 checker flag1", 64'(rec_err(prev, d1)), 64'h1);
    prev = d1;
    @(posedge clk);
    #1;
    chk("T0 post word", 64'(d1), 64'(gold[1002]));
    chk("T0 post ack", 64'(a1), 64'h0);
    chk("T0 checker flag2", 64'(rec_err(prev, d1)), 64'h1);
    prev = d1;
    @(posedge clk);
    #1;
    chk("T0 recover word", 64'(d1), 64'(gold[1003]));
    chk("T0 checker recovered", 64'(rec_err(prev, d1)), 64'h0);
    en1 = 1'b0;

    // 4-bit word counter saturates at 4'hF.
    en2 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        chk("C4 first word", 64'(d2), 64'h02);
        chk("C4 first valid", 64'(v2), 64'h1);
      end
      chk($sformatf("C4 cnt%0d", i), 64'(c2), 64'((i > 15) ? 15 : i));
    end
    chk("C4 no ack", 64'(a2), 64'h0);
    en2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
